// File: rtl/apb_arbiter.sv
// apb_arbiter: two-requester round-robin front end that sequences one APB master through IDLE/SETUP/ACCESS.
module apb_arbiter #(
  parameter int ADDWIDTH  = 8,
  parameter int DATAWIDTH = 32
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   req0_valid,
  input  logic                   req1_valid,
  input  logic                   req0_write,
  input  logic                   req1_write,
  input  logic [ADDWIDTH:0]      req0_addr,
  input  logic [ADDWIDTH:0]      req1_addr,
  input  logic [DATAWIDTH-1:0]   req0_wdata,
  input  logic [DATAWIDTH-1:0]   req1_wdata,
  input  logic [DATAWIDTH/8-1:0] req0_strb,
  input  logic [DATAWIDTH/8-1:0] req1_strb,
  output logic                   req0_accept,
  output logic                   req1_accept,
  output logic                   req0_done,
  output logic                   req1_done,
  output logic [DATAWIDTH-1:0]   rdata,
  output logic                   busy,
  output logic                   m_transfer,
  output logic                   m_write,
  output logic [ADDWIDTH:0]      m_addr,
  output logic [DATAWIDTH-1:0]   m_wdata,
  output logic [DATAWIDTH/8-1:0] m_strb,
  input  logic                   PREADY,
  input  logic [DATAWIDTH-1:0]   m_rdata
);
  typedef enum logic [1:0] {IDLE, START, SETUP, ACCESS} state_t;
  state_t r_state, w_next;
  logic r_owner, r_last;
  logic w_any, w_pick1, w_take, w_fin;
  always_comb begin
    w_any   = req0_valid | req1_valid;
    w_pick1 = req1_valid & (~req0_valid | ~r_last);
    w_take  = (r_state == IDLE) & w_any;
    w_fin   = (r_state == ACCESS) & PREADY;
    w_next  = (r_state == IDLE)  ? (w_any ? START : IDLE) :
              (r_state == START) ? SETUP :
              (r_state == SETUP) ? ACCESS :
              (PREADY ? IDLE : ACCESS);
  end
  assign m_transfer = (r_state == START);
  assign busy       = (r_state != IDLE);
  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      req0_accept <= 1'b0;
      req1_accept <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      rdata       <= '0;
      m_write     <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_strb      <= '0;
    end else begin
      req0_accept <= w_take & ~w_pick1;
      req1_accept <= w_take & w_pick1;
      req0_done   <= w_fin & ~r_owner;
      req1_done   <= w_fin & r_owner;
      if (w_take) begin
        r_owner <= w_pick1;
        m_write <= w_pick1 ? req1_write : req0_write;
        m_addr  <= w_pick1 ? req1_addr  : req0_addr;
        m_wdata <= w_pick1 ? req1_wdata : req0_wdata;
        m_strb  <= w_pick1 ? req1_strb  : req0_strb;
      end
      if (w_fin) begin
        rdata  <= m_rdata;
        r_last <= r_owner;
      end
    end
  end
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: directed checks of grant order, latency, wait states and reset for apb_arbiter.
module tb_apb_arbiter;
  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_write = 1'b0, req1_write = 1'b0;
  logic [8:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_wdata = '0, req1_wdata = '0;
  logic [3:0]  req0_strb = '0, req1_strb = '0;
  logic        req0_accept, req1_accept, req0_done, req1_done;
  logic [31:0] rdata;
  logic        busy, m_transfer, m_write;
  logic [8:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_strb;
  logic        PREADY = 1'b0;
  logic [31:0] m_rdata = '0;
  int total = 0;
  int bad = 0;
  apb_arbiter #(.ADDWIDTH(8), .DATAWIDTH(32)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_write(req0_write), .req1_write(req1_write),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_strb(req0_strb), .req1_strb(req1_strb),
    .req0_accept(req0_accept), .req1_accept(req1_accept),
    .req0_done(req0_done), .req1_done(req1_done),
    .rdata(rdata), .busy(busy), .m_transfer(m_transfer),
    .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_strb(m_strb),
    .PREADY(PREADY), .m_rdata(m_rdata)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask
  initial begin
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_addr  = 9'h001;
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_acc", {30'b0, req1_accept, req0_accept}, 0);
    chk("rst_done", {30'b0, req1_done, req0_done}, 0);
    chk("rst_xfer", {31'b0, m_transfer}, 0);
    chk("rst_addr", {23'b0, m_addr}, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_mw", {27'b0, m_write, m_strb}, 0);
    chk("rst_rdata", rdata, 0);
    PRESET = 1'b0;
    tick();
    chk("rst_first_acc", {30'b0, req1_accept, req0_accept}, 32'h1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    PREADY = 1'b1;
    tick(); tick(); tick();
    chk("rst_first_done", {30'b0, req1_done, req0_done}, 32'h1);
    // single read
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h105;
    m_rdata = 32'hDEADBEEF;
    tick();
    chk("rd_acc", {30'b0, req1_accept, req0_accept}, 32'h1);
    chk("rd_xfer_start", {31'b0, m_transfer}, 1);
    chk("rd_addr", {23'b0, m_addr}, 32'h105);
    chk("rd_write", {31'b0, m_write}, 0);
    req0_valid = 1'b0;
    tick();
    chk("rd_xfer_setup", {31'b0, m_transfer}, 0);
    chk("rd_acc_pulse", {31'b0, req0_accept}, 0);
    tick();
    chk("rd_xfer_access", {31'b0, m_transfer}, 0);
    chk("rd_early_done", {31'b0, req0_done}, 0);
    tick();
    chk("rd_done", {30'b0, req1_done, req0_done}, 32'h1);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_busy_end", {31'b0, busy}, 0);
    // write with three wait states
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 9'h0AA;
    req1_wdata = 32'h12345678; req1_strb = 4'hF;
    PREADY = 1'b0; m_rdata = 32'h0BADF00D;
    tick();
    chk("wr_acc", {30'b0, req1_accept, req0_accept}, 32'h2);
    req1_valid = 1'b0; req1_wdata = 32'h0; req1_addr = 9'h0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_wait_done", {30'b0, req1_done, req0_done}, 0);
      chk("wr_wait_busy", {31'b0, busy}, 1);
      chk("wr_wait_wdata", m_wdata, 32'h12345678);
      chk("wr_wait_cmd", {18'b0, m_write, m_strb, m_addr}, {18'b0, 1'b1, 4'hF, 9'h0AA});
    end
    PREADY = 1'b1;
    tick();
    chk("wr_done", {30'b0, req1_done, req0_done}, 32'h2);
    chk("wr_rdata", rdata, 32'h0BADF00D);
    // fairness: last owner was req1, so req0 leads
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 9'h010; req1_addr = 9'h120; req0_write = 1'b0; req1_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fair_acc", {30'b0, req1_accept, req0_accept}, (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("fair_addr", {23'b0, m_addr}, (k % 2 == 0) ? 32'h010 : 32'h120);
      tick();
      chk("fair_gap1", {30'b0, req1_accept, req0_accept}, 0);
      tick();
      chk("fair_gap2", {30'b0, req1_accept, req0_accept}, 0);
      tick();
      chk("fair_done", {30'b0, req1_done, req0_done}, (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("fair_gap3", {30'b0, req1_accept, req0_accept}, 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    // late arrival of req1 during req0's ACCESS
    req0_valid = 1'b1; req0_addr = 9'h033;
    tick();
    chk("late_acc0", {30'b0, req1_accept, req0_accept}, 32'h1);
    req0_valid = 1'b0;
    PREADY = 1'b0;
    tick(); tick();
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 9'h1FF;
    req1_wdata = 32'hCAFEF00D; req1_strb = 4'h3;
    tick();
    chk("late_no_acc", {30'b0, req1_accept, req0_accept}, 0);
    chk("late_cmd_hold", {22'b0, m_write, m_addr}, {22'b0, 1'b0, 9'h033});
    PREADY = 1'b1; m_rdata = 32'h11112222;
    tick();
    chk("late_done0", {30'b0, req1_done, req0_done}, 32'h1);
    chk("late_rdata", rdata, 32'h11112222);
    chk("late_no_acc2", {31'b0, req1_accept}, 0);
    tick();
    chk("late_acc1", {30'b0, req1_accept, req0_accept}, 32'h2);
    chk("late_cmd1", {18'b0, m_write, m_strb, m_addr}, {18'b0, 1'b1, 4'h3, 9'h1FF});
    chk("late_wdata1", m_wdata, 32'hCAFEF00D);
    req1_valid = 1'b0;
    tick(); tick(); tick();
    chk("late_done1", {30'b0, req1_done, req0_done}, 32'h2);
    // reset during ACCESS with req0 still holding valid
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 9'h044; req0_wdata = 32'hA5A5A5A5;
    tick();
    chk("mr_acc", {30'b0, req1_accept, req0_accept}, 32'h1);
    PREADY = 1'b0;
    tick(); tick();
    chk("mr_in_access", {31'b0, busy}, 1);
    PRESET = 1'b1;
    PREADY = 1'b1;
    tick();
    chk("mr_done", {30'b0, req1_done, req0_done}, 0);
    chk("mr_busy", {31'b0, busy}, 0);
    chk("mr_addr", {23'b0, m_addr}, 0);
    chk("mr_rdata", rdata, 0);
    PRESET = 1'b0;
    tick();
    chk("mr_reacc", {30'b0, req1_accept, req0_accept}, 32'h1);
    chk("mr_cmd", {22'b0, m_write, m_addr}, {22'b0, 1'b1, 9'h044});
    req0_valid = 1'b0;
    m_rdata = 32'h5;
    tick(); tick(); tick();
    chk("mr_final_done", {30'b0, req1_done, req0_done}, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-requester round-robin arbiter that shares a single `apbMaster` instance. It captures a requester's command, sequences the master's `transfer` input, and tracks the master's IDLE/SETUP/ACCESS progress cycle-for-cycle. It returns read data and a completion pulse to the requester that owned the transfer. It sits between the top-level command sources and the master.

## Interface
Parameters:
- `ADDWIDTH`, 8: address width. Requester addresses are `ADDWIDTH+1` bits; the MSB selects the slave, as the master decodes it.
- `DATAWIDTH`, 32: data width. Strobe width is `DATAWIDTH/8`.

Ports:
- `PCLK`  in  1  Single clock; everything changes on the rising edge.
- `PRESET`  in  1  Reset, synchronous and active-high.
- `req0_valid`, `req1_valid`  in  1  Request pending. Hold valid and payload until the matching `reqN_accept` pulse.
- `req0_write`, `req1_write`  in  1  1 = write, 0 = read.
- `req0_addr`, `req1_addr`  in  ADDWIDTH+1  Address, including the slave-select MSB.
- `req0_wdata`, `req1_wdata`  in  DATAWIDTH  Write data.
- `req0_strb`, `req1_strb`  in  DATAWIDTH/8  Write strobes.
- `req0_accept`, `req1_accept`  out  1  One-cycle pulse: command captured.
- `req0_done`, `req1_done`  out  1  One-cycle pulse: transfer complete; `rdata` valid in the same cycle.
- `rdata`  out  DATAWIDTH  Read data, registered on completion and shared by both requesters.
- `busy`  out  1  High whenever the arbiter is not in IDLE.
- `m_transfer`  out  1  To the master's `transfer` input.
- `m_write`, `m_addr`, `m_wdata`, `m_strb`  out  1 / ADDWIDTH+1 / DATAWIDTH / DATAWIDTH/8  To the master's `PWRITEin`, `PADDRin`, `PWDATAin` and `PSTRBin`. All are registered and stable for the whole transfer.
- `PREADY`  in  1  Slave ready, the same net the master sees.
- `m_rdata`  in  DATAWIDTH  From the master's `PRDATAout`.

## Operation
- Registered state: the FSM state, the captured command (`m_*`), `owner` (1 bit), `last` (1 bit, last owner), and `rdata`.
- FSM states and transitions:
  - IDLE: if neither `reqN_valid` is high, stay. Otherwise pick the winner, capture its command into `m_*`, set `owner` to the winner, pulse `reqN_accept` for the winner, and go to START.
  - START: `m_transfer` = 1 (the master is in IDLE and samples it). Go to SETUP.
  - SETUP: `m_transfer` = 0 (the master is in SETUP). Go to ACCESS.
  - ACCESS: `m_transfer` = 0 (the master is in ACCESS).
    - `PREADY` = 0: stay.
    - `PREADY` = 1: capture `m_rdata` into `rdata`, pulse `reqN_done` for `owner`, set `last` to `owner`, and go to IDLE.
- Because `m_transfer` is held at 0 in ACCESS, the master always returns to IDLE, so its SETUP→SETUP back-to-back path is never used.
- Arbitration:
  - Only one request valid: grant it.
  - Both requests valid: grant the requester that is not `last`.
  - `last` resets to 1, so req0 wins the first tie.
- `reqN_accept` and `reqN_done` are registered pulses, mutually exclusive between requesters.
- `rdata` is updated only on read or write completion; it holds otherwise. On a write it still captures `m_rdata` and is don't-care to the requester.
- Requests arriving while `busy` = 1 wait; they are never dropped.

## Timing
- Reset (`PRESET` = 1 at a rising edge), from the next cycle:
  - state = IDLE; `last` = 1; `owner` = 0.
  - `m_transfer`, `m_write`, `busy`, all `reqN_accept` and all `reqN_done` = 0.
  - `m_addr`, `m_wdata`, `m_strb`, `rdata` = 0.
- Reset mid-transfer aborts with no `done` pulse. The master must share `PRESET` (inverted onto its `PRESETn`) so both return to IDLE in the same cycle.
- Latency, with edge E being the one where IDLE sees valid:
  - Edge E: `accept` pulses and START begins.
  - E+1: SETUP.
  - E+2: ACCESS.
  - `done` is high in the cycle after the first ACCESS cycle with `PREADY` = 1, i.e. at the earliest E+3.
- Each wait state (`PREADY` = 0 in ACCESS) adds one cycle.
- Back-to-back throughput: `done` is issued on the edge that returns to IDLE. The next `accept` comes on the following edge, giving a minimum 4-cycle period per transfer.
- `m_*` changes only on the edge that leaves IDLE.
- `PREADY` is ignored outside ACCESS.
- A requester's `valid` dropping before `accept` withdraws the request. `valid` dropping after `accept` has no effect.

## Test plan
- Reset: hold `PRESET` for 2 cycles with both valids high -> all outputs 0 and no accept. After release, req0 is accepted first.
- Single read: req0 reads `addr` = 0x105, `PREADY` = 1, `m_rdata` = 0xDEADBEEF -> `m_transfer` high only in the START cycle, `m_addr` = 0x105, then `req0_done` with `rdata` = 0xDEADBEEF at E+3.
- Wait states: req1 writes `wdata` = 0x12345678 with `strb` = 0xF, `PREADY` low for 3 ACCESS cycles -> `m_*` stable throughout, `req1_done` at E+6, and `req0_done` never pulses.
- Fairness: both valids held for 4 transfers -> grant order req0, req1, req0, req1, with accepts exactly 4 cycles apart when `PREADY` = 1.
- Late arrival: req1 raises valid while req0 is in ACCESS -> req1 is accepted on the edge after `req0_done`, with no command corruption.
- Mid-transfer reset: assert `PRESET` in ACCESS -> no `done` pulse, state IDLE, `busy` = 0, and a held request is re-accepted after release.
